mem_port_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 28 ++
 rtl/mem_arb_timer.sv | 33 +++
 rtl/mem_port_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/MEM memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_I = 2'b01,
    GNT_D = 2'b10,
    RESP  = 2'b11
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_e;

  localparam int unsigned TIMEOUT_CYC_DEF = 255;

  // Smallest width in 8..16 whose range can hold cyc.
  function automatic int unsigned tmo_cnt_width(input int unsigned cyc);
    int unsigned w;
    w = 16;
    for (int unsigned i = 16; i >= 8; i--) begin
      if ((64'd1 << i) > 64'(cyc)) w = i;
    end
    return w;
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Memory-wait watchdog: counts unacknowledged grant cycles, flags the last allowed one.
module mem_arb_timer
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned   CW   = tmo_cnt_width(TIMEOUT_CYC);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + 1'b1;
  end

  // Fires in the cycle whose increment would make the count reach TIMEOUT_CYC.
  assign expired = en && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one req/ack memory port between IF and MEM stages with fetch-drop on flush.
// Optional memory watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  input  logic            if_flush,
  output logic            if_ack,
  output logic [DW-1:0]   if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_ack,
  output logic [DW-1:0]   d_rdata,
  output logic            m_req,
  output logic            m_we,
  output logic [DW/8-1:0] m_be,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  input  logic [DW-1:0]   m_rdata,
  input  logic            m_ack,
  output logic            busy,
  output logic            timeout_err
);

  localparam int unsigned BW = DW / 8;

  arb_state_e     state_q, state_d;
  arb_owner_e     last_own_q, last_own_d;
  logic           drop_q, drop_d;
  logic           m_req_q, m_req_d;
  logic           m_we_q, m_we_d;
  logic [BW-1:0]  m_be_q, m_be_d;
  logic [AW-1:0]  m_addr_q, m_addr_d;
  logic [DW-1:0]  m_wdata_q, m_wdata_d;
  logic           if_ack_q, if_ack_d;
  logic           d_ack_q, d_ack_d;
  logic [DW-1:0]  if_rdata_q, if_rdata_d;
  logic [DW-1:0]  d_rdata_q, d_rdata_d;
  logic           timeout_err_q, timeout_err_d;

  logic           if_go;
  logic           tmo_hit;
  logic [DW-1:0]  resp_data;

  assign if_go = if_req & ~if_flush;

`ifdef MEM_ARB_TIMEOUT_EN
  logic grant;
  logic tmo_en;

  assign grant  = (state_q == IDLE) && (d_req || if_go);
  assign tmo_en = ((state_q == GNT_I) || (state_q == GNT_D)) && !m_ack;

  mem_arb_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (grant),
    .en      (tmo_en),
    .expired (tmo_hit)
  );
`else
  // TIMEOUT_CYC has no effect without the watchdog.
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TIMEOUT_CYC;
  assign tmo_hit        = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    last_own_d    = last_own_q;
    drop_d        = drop_q;
    m_req_d       = m_req_q;
    m_we_d        = m_we_q;
    m_be_d        = m_be_q;
    m_addr_d      = m_addr_q;
    m_wdata_d     = m_wdata_q;
    if_ack_d      = 1'b0;
    d_ack_d       = 1'b0;
    if_rdata_d    = if_rdata_q;
    d_rdata_d     = d_rdata_q;
    timeout_err_d = timeout_err_q | tmo_hit;
    resp_data     = m_ack ? m_rdata : '0;

    unique case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        // Data wins contention unless it won the previous grant.
        if (d_req && !(if_go && last_own_q == OWN_D)) begin
          state_d    = GNT_D;
          last_own_d = OWN_D;
          m_req_d    = 1'b1;
          m_we_d     = d_we;
          m_be_d     = d_be;
          m_addr_d   = d_addr;
          m_wdata_d  = d_wdata;
        end else if (if_go) begin
          state_d    = GNT_I;
          last_own_d = OWN_I;
          m_req_d    = 1'b1;
          m_we_d     = 1'b0;
          m_be_d     = '1;
          m_addr_d   = if_addr;
          m_wdata_d  = '0;
        end
      end
      GNT_I: begin
        if (if_flush) drop_d = 1'b1;
        if (m_ack || tmo_hit) begin
          state_d = RESP;
          m_req_d = 1'b0;
          if (!(drop_q || if_flush)) begin
            if_ack_d   = 1'b1;
            if_rdata_d = resp_data;
          end
        end
      end
      GNT_D: begin
        if (m_ack || tmo_hit) begin
          state_d   = RESP;
          m_req_d   = 1'b0;
          d_ack_d   = 1'b1;
          d_rdata_d = resp_data;
        end
      end
      RESP: begin
        state_d = IDLE;
        drop_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      last_own_q    <= OWN_I;
      drop_q        <= 1'b0;
      m_req_q       <= 1'b0;
      m_we_q        <= 1'b0;
      m_be_q        <= '0;
      m_addr_q      <= '0;
      m_wdata_q     <= '0;
      if_ack_q      <= 1'b0;
      d_ack_q       <= 1'b0;
      if_rdata_q    <= '0;
      d_rdata_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_own_q    <= last_own_d;
      drop_q        <= drop_d;
      m_req_q       <= m_req_d;
      m_we_q        <= m_we_d;
      m_be_q        <= m_be_d;
      m_addr_q      <= m_addr_d;
      m_wdata_q     <= m_wdata_d;
      if_ack_q      <= if_ack_d;
      d_ack_q       <= d_ack_d;
      if_rdata_q    <= if_rdata_d;
      d_rdata_q     <= d_rdata_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // A flush arriving in the response cycle itself must still swallow the fetch ack.
  assign if_ack      = if_ack_q & ~if_flush;
  assign if_rdata    = if_rdata_q;
  assign d_ack       = d_ack_q;
  assign d_rdata     = d_rdata_q;
  assign m_req       = m_req_q;
  assign m_we        = m_we_q;
  assign m_be        = m_be_q;
  assign m_addr      = m_addr_q;
  assign m_wdata     = m_wdata_q;
  assign busy        = (state_q != IDLE);
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_flush, if_ack;
  logic [31:0]   if_addr, if_rdata;
  logic          d_req, d_we, d_ack;
  logic [3:0]    d_be;
  logic [31:0]   d_addr, d_wdata, d_rdata;
  logic          m_req, m_we;
  logic [3:0]    m_be;
  logic [31:0]   m_addr, m_wdata;
  logic [31:0]   m_rdata = '0;
  logic          m_ack = 1'b0;
  logic          busy, timeout_err;

  int unsigned   n_cmp = 0;
  int unsigned   n_err = 0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Memory seen by the DUT and the reference copy the model predicts from.
  logic [31:0] mem     [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return dflt(a);
  endfunction

  function automatic logic [31:0] rd_ref(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return dflt(a);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory responder: acks after mem_wait extra cycles, tracks the request burst.
  int unsigned mem_wait = 0;
  int unsigned wcnt = 0, req_cycles = 0, acks_given = 0;
  bit          in_burst = 1'b0;
  logic [31:0] cap_addr = '0, cap_wdata = '0;
  logic        cap_we = 1'b0;
  logic [3:0]  cap_be = '0;

  always @(negedge clk) begin
    if (m_req === 1'b1) begin
      if (!in_burst) begin
        in_burst = 1'b1; wcnt = 0; req_cycles = 0;
        cap_addr = m_addr; cap_we = m_we; cap_be = m_be; cap_wdata = m_wdata;
      end else begin
        chk("m_addr_stable", m_addr, cap_addr);
        chk("m_ctl_stable", {m_we, m_be, m_wdata}, {cap_we, cap_be, cap_wdata});
      end
      req_cycles++;
      if (wcnt == mem_wait) begin
        m_ack   = 1'b1;
        m_rdata = rd_mem(m_addr);
        if (m_we) mem[m_addr] = merge(rd_mem(m_addr), m_wdata, m_be);
        acks_given++;
      end else begin
        m_ack   = 1'b0;
        m_rdata = $urandom;
        wcnt++;
      end
    end else begin
      in_burst = 1'b0;
      m_ack    = 1'b0;
      m_rdata  = $urandom;
    end
  end

  bit last_d = 1'b0;   // model: previous grant went to data

  // Called at the negedge of an IDLE cycle with requests already driven.
  task automatic serve(input bit exp_d, input int unsigned w);
    logic [31:0] ea, ed;
    logic        ewe;
    logic [3:0]  ebe;
    int unsigned k;
    bit          got;
    mem_wait = w;
    if (exp_d) begin ea = d_addr; ewe = d_we; ebe = d_be; end
    else       begin ea = if_addr; ewe = 1'b0; ebe = 4'hF; end
    ed     = rd_ref(ea);
    last_d = exp_d;
    k = 0; got = 1'b0;
    while (!got && k < 40) begin
      @(negedge clk);
      k++;
      if (k == 1) chk("m_req_cycle1", m_req, 1);
      if (if_ack === 1'b1 || d_ack === 1'b1) got = 1'b1;
    end
    chk("ack_latency", k, 2 + w);
    chk("ack_owner_d", d_ack, exp_d);
    chk("ack_owner_i", if_ack, !exp_d);
    chk("m_addr", cap_addr, ea);
    chk("m_we", cap_we, ewe);
    chk("m_be", cap_be, ebe);
    chk("m_req_cycles", req_cycles, w + 1);
    if (ewe) begin
      chk("m_wdata", cap_wdata, d_wdata);
      ref_mem[ea] = merge(ed, d_wdata, d_be);
    end else begin
      chk("rdata", exp_d ? d_rdata : if_rdata, ed);
    end
    if (exp_d) d_req = 1'b0; else if_req = 1'b0;
    @(negedge clk);
    chk("busy_after", busy, 0);
    chk("ack_single", {if_ack, d_ack}, 0);
    if (!ewe) chk("rdata_hold", exp_d ? d_rdata : if_rdata, ed);
  endtask

  initial begin
    logic [31:0] prev;
    int unsigned a0, k, r;
    bit          got, seen, pi, pd, first;

    rst = 1'b1; if_req = 0; if_flush = 0; if_addr = '0;
    d_req = 0; d_we = 0; d_be = '0; d_addr = '0; d_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_m_req", m_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_acks", {if_ack, d_ack}, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_m_fields", {m_we, m_be} ^ m_addr ^ m_wdata, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    // Single fetch, memory acks in the first request cycle.
    mem[32'h40] = 32'h00A00093; ref_mem[32'h40] = 32'h00A00093;
    if_addr = 32'h40; if_req = 1'b1;
    serve(1'b0, 0);

    // Contention round 1: after reset data goes first, then fetch.
    d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
    if_req = 1; if_addr = 32'h44;
    serve(1'b1, 0);
    serve(1'b0, 1);
    // Round 2: last grant was fetch, so data first; load sees the partial store.
    d_req = 1; d_we = 0; d_addr = 32'h100; if_req = 1; if_addr = 32'h48;
    serve(1'b1, 2);
    serve(1'b0, 0);
    // Data alone, then contention: fetch must win this time.
    d_req = 1; d_we = 1; d_be = 4'hF; d_addr = 32'h104; d_wdata = 32'hCAFEF00D;
    serve(1'b1, 1);
    d_req = 1; d_we = 0; d_addr = 32'h104; if_req = 1; if_addr = 32'h100;
    serve(1'b0, 0);
    serve(1'b1, 0);

    // Load with three memory wait cycles.
    mem[32'h200] = 32'h12345678; ref_mem[32'h200] = 32'h12345678;
    d_req = 1; d_we = 0; d_addr = 32'h200;
    serve(1'b1, 3);

    // Flush during GNT_I: access completes, ack dropped, rdata held.
    prev = if_rdata; a0 = acks_given; mem_wait = 1;
    if_addr = 32'h300; if_req = 1;
    @(negedge clk);
    chk("flush_gnt_m_req", m_req, 1);
    if_flush = 1; if_req = 0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if_flush = 0;
      seen |= (if_ack === 1'b1);
    end
    chk("flush_no_ack", seen, 0);
    chk("flush_mem_done", acks_given, a0 + 1);
    chk("flush_rdata_held", if_rdata, prev);
    chk("flush_busy", busy, 0);
    last_d = 0;
    if_addr = 32'h304; if_req = 1;
    serve(1'b0, 0);

    // Flush arriving in the response cycle also swallows the ack.
    mem_wait = 0; if_addr = 32'h308; if_req = 1;
    @(negedge clk);
    @(negedge clk);
    if_flush = 1; if_req = 0;
    #1;
    chk("flush_resp_no_ack", if_ack, 0);
    chk("flush_resp_busy", busy, 1);
    @(negedge clk);
    if_flush = 0;
    chk("flush_resp_idle", busy, 0);
    last_d = 0;

    // Flush never affects data; a flushed fetch request in IDLE is ignored.
    if_flush = 1; if_req = 1; if_addr = 32'h40;
    d_req = 1; d_we = 0; d_addr = 32'h200;
    serve(1'b1, 1);
    @(negedge clk);
    chk("flushed_fetch_ignored", {busy, m_req}, 0);
    if_flush = 0;
    serve(1'b0, 0);

    // Reset in the middle of a data grant.
    d_req = 1; d_we = 0; d_addr = 32'h200; mem_wait = 100;
    @(negedge clk);
    @(negedge clk);
    rst = 1; d_req = 0;
    @(negedge clk);
    chk("rst_gnt_m_req", m_req, 0);
    chk("rst_gnt_busy", busy, 0);
    chk("rst_gnt_ack", d_ack, 0);
    chk("rst_gnt_rdata", d_rdata, 0);
    chk("rst_gnt_tmo", timeout_err, 0);
    rst = 0; mem_wait = 0; last_d = 0;
    @(negedge clk);

    // Randomized traffic against the transaction-level model.
    for (int it = 0; it < 40; it++) begin
      r  = $urandom_range(0, 2);
      pi = (r != 1); pd = (r != 0);
      if_addr = 32'h1000 + 4 * $urandom_range(0, 15);
      d_addr  = 32'h1000 + 4 * $urandom_range(0, 15);
      d_we    = 1'($urandom_range(0, 1));
      d_be    = 4'($urandom_range(1, 15));
      d_wdata = $urandom;
      if_req  = pi; d_req = pd;
      first   = pd && (!pi || !last_d);
      serve(first, $urandom_range(0, 3));
      if (pi && pd) serve(!first, $urandom_range(0, 3));
    end
    chk("no_timeout_err", timeout_err, 0);

`ifdef MEM_ARB_TIMEOUT_EN
    d_req = 1; d_we = 0; d_addr = 32'h200; mem_wait = 1000;
    k = 0; got = 0;
    while (!got && k < 40) begin
      @(negedge clk);
      k++;
      if (d_ack === 1'b1) got = 1;
    end
    chk("tmo_latency", k, 5);
    chk("tmo_req_cycles", req_cycles, 4);
    chk("tmo_rdata", d_rdata, 0);
    chk("tmo_err_set", timeout_err, 1);
    d_req = 0; mem_wait = 0; last_d = 1;
    @(negedge clk);
    if_req = 1; if_addr = 32'h40;
    serve(1'b0, 0);
    chk("tmo_err_sticky", timeout_err, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("tmo_err_cleared", timeout_err, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
